// File: rtl/barcode_cmp_ctrl.sv
// Start/busy/done sequencer that walks a shared address over two barcode RAMs
// and reports match, mismatch count and first mismatching address.
//
// state | meaning
// IDLE  | wait for start
// RUN   | issue one read per cycle, addresses 0..len-1
// DRAIN | wait for the last read to return and be compared
// DONE  | pulse done for one cycle
module barcode_cmp_ctrl #(
  parameter int DATA_W      = 128,
  parameter int DEPTH       = 1958,
  parameter int ADDR_W      = 11,
  parameter bit EARLY_ABORT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [ADDR_W:0]   mismatch_cnt,
  output logic [ADDR_W-1:0] first_mis_addr,
  output logic              first_mis_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len_clamp;
  logic [ADDR_W:0]   len_m1;
  logic [ADDR_W-1:0] last_addr;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              active, cmp_en, word_ne, stop_early, accept;

  assign len_clamp  = (len > DEPTH_L) ? DEPTH_L : len;
  assign len_m1     = len_clamp - 1'b1;
  assign active     = (state == RUN) || (state == DRAIN);
  assign accept     = (state == IDLE) && start;
  // Reads still in flight after the run has left RUN/DRAIN are discarded.
  assign cmp_en     = cmp_vld && active && !abort;
  assign word_ne    = (rd_data_a !== rd_data_b);
  assign stop_early = EARLY_ABORT && cmp_en && word_ne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len_clamp == '0) ? DONE : RUN;
      RUN: begin
        if (abort)                   state_nxt = IDLE;
        else if (stop_early)         state_nxt = DONE;
        else if (rd_addr == last_addr) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = abort ? IDLE : DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      last_addr <= '0;
      cmp_vld   <= 1'b0;
      cmp_addr  <= '0;
    end else begin
      rd_en    <= (state_nxt == RUN);
      busy     <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done     <= (state_nxt == DONE);
      cmp_vld  <= rd_en;
      cmp_addr <= rd_addr;
      if (accept) begin
        rd_addr   <= '0;
        last_addr <= len_m1[ADDR_W-1:0];
      end else if (state == RUN && state_nxt == RUN) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match           <= 1'b0;
      mismatch_cnt    <= '0;
      first_mis_addr  <= '0;
      first_mis_valid <= 1'b0;
    end else if (accept) begin
      match           <= 1'b1;
      mismatch_cnt    <= '0;
      first_mis_addr  <= '0;
      first_mis_valid <= 1'b0;
    end else if (active && abort) begin
      match <= 1'b0;
    end else if (cmp_en && word_ne) begin
      match <= 1'b0;
      if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
      if (!first_mis_valid) begin
        first_mis_addr  <= cmp_addr;
        first_mis_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_barcode_cmp_ctrl.sv
// Randomized bench for barcode_cmp_ctrl: a full-run and an early-abort instance
// share stimulus and are checked against a memory-scan reference model.
module tb_barcode_cmp_ctrl;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 1958;
  localparam int ADDR_W = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [ADDR_W:0] len = '0;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  logic              rd_en_f, busy_f, done_f, match_f, fmv_f;
  logic [ADDR_W-1:0] rd_addr_f, fma_f;
  logic [ADDR_W:0]   cnt_f;
  logic [DATA_W-1:0] da_f, db_f;

  logic              rd_en_e, busy_e, done_e, match_e, fmv_e;
  logic [ADDR_W-1:0] rd_addr_e, fma_e;
  logic [ADDR_W:0]   cnt_e;
  logic [DATA_W-1:0] da_e, db_e;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  barcode_cmp_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .EARLY_ABORT(1'b0)) u_dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .rd_en(rd_en_f), .rd_addr(rd_addr_f), .rd_data_a(da_f), .rd_data_b(db_f),
    .busy(busy_f), .done(done_f), .match(match_f), .mismatch_cnt(cnt_f),
    .first_mis_addr(fma_f), .first_mis_valid(fmv_f));

  barcode_cmp_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .EARLY_ABORT(1'b1)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .rd_en(rd_en_e), .rd_addr(rd_addr_e), .rd_data_a(da_e), .rd_data_b(db_e),
    .busy(busy_e), .done(done_e), .match(match_e), .mismatch_cnt(cnt_e),
    .first_mis_addr(fma_e), .first_mis_valid(fmv_e));

  // Synchronous-read RAMs, one cycle of latency.
  always @(posedge clk) begin
    if (rd_en_f) begin da_f <= mem_a[rd_addr_f]; db_f <= mem_b[rd_addr_f]; end
    if (rd_en_e) begin da_e <= mem_a[rd_addr_e]; db_e <= mem_b[rd_addr_e]; end
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic fill_equal();
    for (int k = 0; k < DEPTH; k++) begin
      mem_a[k] = {$urandom, $urandom, $urandom, $urandom};
      mem_b[k] = mem_a[k];
    end
  endtask

  task automatic flip(input int addr);
    mem_b[addr][$urandom_range(DATA_W-1, 0)] ^= 1'b1;
  endtask

  function automatic int pack_outs(input logic b, input logic d, input logic r, input logic m,
                                   input logic v, input logic [ADDR_W-1:0] a,
                                   input logic [ADDR_W:0] c, input logic [ADDR_W-1:0] f);
    return int'(b) + int'(d) + int'(r) + int'(m) + int'(v) + int'(a) + int'(c) + int'(f);
  endfunction

  task automatic run_cmp(input int l_in, input bit mid_start, input bit abort_too);
    int lc, cnt, first, exp_d_e, exp_rd_e;
    int d_f, d_e, nrd_f, nrd_e, aerr, ndone_f, ndone_e, busy1;
    logic m_f, v_f, m_e, v_e, bz_f;
    logic [ADDR_W:0] c_f, c_e;
    logic [ADDR_W-1:0] a_f, a_e;
    lc = (l_in > DEPTH) ? DEPTH : l_in;
    cnt = 0; first = -1;
    for (int k = 0; k < lc; k++)
      if (mem_a[k] !== mem_b[k]) begin
        cnt++;
        if (first < 0) first = k;
      end
    if (cnt == 0) begin exp_d_e = (lc == 0) ? 1 : lc + 2; exp_rd_e = lc; end
    else begin exp_d_e = first + 3; exp_rd_e = (first + 2 < lc) ? first + 2 : lc; end

    @(negedge clk);
    len = l_in[ADDR_W:0]; start = 1'b1; abort = abort_too;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    d_f = -1; d_e = -1; nrd_f = 0; nrd_e = 0; aerr = 0; ndone_f = 0; ndone_e = 0;
    busy1 = busy_f;
    m_f = 0; v_f = 0; m_e = 0; v_e = 0; bz_f = 1; c_f = 0; c_e = 0; a_f = 0; a_e = 0;
    for (int c = 1; c <= lc + 10; c++) begin
      if (c > 1) @(negedge clk);
      if (rd_en_f) begin nrd_f++; if (int'(rd_addr_f) != c - 1) aerr++; end
      if (rd_en_e) nrd_e++;
      if (done_f) begin
        ndone_f++;
        if (d_f < 0) begin d_f = c; m_f = match_f; c_f = cnt_f; v_f = fmv_f; a_f = fma_f; bz_f = busy_f; end
      end
      if (done_e) begin
        ndone_e++;
        if (d_e < 0) begin d_e = c; m_e = match_e; c_e = cnt_e; v_e = fmv_e; a_e = fma_e; end
      end
      if (mid_start && c == 10) begin start = 1'b1; len = 7; end
      else if (mid_start && c == 11) start = 1'b0;
    end
    chk("busy_rise", busy1, (lc > 0) ? 1 : 0);
    chk("rd_count", nrd_f, lc);
    chk("rd_addr_order", aerr, 0);
    chk("done_cycle", d_f, (lc == 0) ? 1 : lc + 2);
    chk("done_pulses", ndone_f, 1);
    chk("busy_at_done", bz_f, 0);
    chk("match", m_f, (cnt == 0) ? 1 : 0);
    chk("mis_cnt", c_f, cnt);
    chk("first_valid", v_f, (cnt > 0) ? 1 : 0);
    if (cnt > 0) chk("first_addr", a_f, first);
    chk("match_held", match_f, (cnt == 0) ? 1 : 0);
    chk("ea_done_cycle", d_e, exp_d_e);
    chk("ea_done_pulses", ndone_e, 1);
    chk("ea_rd_count", nrd_e, exp_rd_e);
    chk("ea_mis_cnt", c_e, (cnt > 0) ? 1 : 0);
    chk("ea_match", m_e, (cnt == 0) ? 1 : 0);
    chk("ea_first_valid", v_e, (cnt > 0) ? 1 : 0);
    if (cnt > 0) chk("ea_first_addr", a_e, first);
  endtask

  task automatic wait_addr(input int addr, output bit ok);
    ok = 0;
    for (int i = 0; i < addr + 20 && !ok; i++) begin
      @(negedge clk);
      if (rd_en_f && int'(rd_addr_f) == addr) ok = 1;
    end
    chk("addr_reached", ok, 1);
  endtask

  initial begin
    bit ok;
    int nd, l, nmis;
    fill_equal();
    #23;
    chk("rst_outs_f", pack_outs(busy_f, done_f, rd_en_f, match_f, fmv_f, rd_addr_f, cnt_f, fma_f), 0);
    chk("rst_outs_e", pack_outs(busy_e, done_e, rd_en_e, match_e, fmv_e, rd_addr_e, cnt_e, fma_e), 0);
    @(negedge clk); rst_n = 1'b1;

    run_cmp(DEPTH, 1'b1, 1'b0);
    flip(5); flip(1000);
    run_cmp(DEPTH, 1'b0, 1'b0);
    run_cmp(0, 1'b0, 1'b0);
    run_cmp(50, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) mem_b[k] = mem_a[k];
    run_cmp(3000, 1'b0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < DEPTH; k++) mem_b[k] = mem_a[k];
      l = ($urandom_range(3, 0) == 0) ? $urandom_range(2100, 1) : $urandom_range(300, 1);
      nmis = $urandom_range(3, 0);
      for (int j = 0; j < nmis; j++) flip($urandom_range(((l < DEPTH) ? l : DEPTH) - 1, 0));
      run_cmp(l, 1'b0, 1'b0);
    end

    // abort mid-run
    for (int k = 0; k < DEPTH; k++) mem_b[k] = mem_a[k];
    @(negedge clk); len = DEPTH; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_addr(100, ok);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy_f, 0);
    chk("abort_rd_en", rd_en_f, 0);
    chk("abort_match", match_f, 0);
    chk("abort_busy_ea", busy_e, 0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_f || done_e) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);

    // asynchronous reset mid-run
    @(negedge clk); len = DEPTH; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_addr(50, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs_f", pack_outs(busy_f, done_f, rd_en_f, match_f, fmv_f, rd_addr_f, cnt_f, fma_f), 0);
    chk("arst_outs_e", pack_outs(busy_e, done_e, rd_en_e, match_e, fmv_e, rd_addr_e, cnt_e, fma_e), 0);
    @(negedge clk); rst_n = 1'b1;
    flip(777);
    run_cmp(DEPTH, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/barcode_cmp_ctrl.md
# barcode_cmp_ctrl

Sequencer for the barcode matcher datapath: on a start pulse it walks a shared read address across the sample and test barcode memories, compares the two 128-bit words returned at each address, and reports an overall match, a mismatch count and the first mismatching address. It replaces free-running, self-triggered comparison with a deterministic start/busy/done handshake. Both memories sit outside the block as synchronous-read RAMs with one cycle of read latency.

## Interface
- DATA_W, 128, barcode word width
- DEPTH, 1958, words per barcode memory
- ADDR_W, 11, address width, with 2^ADDR_W >= DEPTH
- EARLY_ABORT, 0, when 1, stop at the first mismatch

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a compare; sampled only in IDLE
- len  in  ADDR_W+1  words to compare; latched at start; values above DEPTH are clamped to DEPTH
- abort  in  1  cancel the run in progress
- rd_en  out  1  read strobe to both memories
- rd_addr  out  ADDR_W  shared read address
- rd_data_a  in  DATA_W  sample word, valid the cycle after rd_en
- rd_data_b  in  DATA_W  test word, valid the cycle after rd_en
- busy  out  1  high from the cycle after an accepted start until done or abort
- done  out  1  one-cycle pulse when results are final
- match  out  1  1 when all compared words were equal; held until the next accepted start
- mismatch_cnt  out  ADDR_W+1  number of unequal word pairs; saturates at all-ones
- first_mis_addr  out  ADDR_W  address of the first mismatch
- first_mis_valid  out  1  first_mis_addr is meaningful

## Operation
- States:
  - IDLE: wait for start.
  - RUN: issue reads.
  - DRAIN: wait for the last read to return.
  - DONE: pulse done for one cycle, then go to IDLE.
- IDLE + start: latch the clamped len. Clear mismatch_cnt, first_mis_addr and first_mis_valid. Set match=1.
  - len==0: go to DONE.
  - otherwise: go to RUN.
- RUN: assert rd_en each cycle with rd_addr = 0, 1, …, len-1. After issuing len-1, go to DRAIN.
- Compare stage:
  - A one-bit valid, delayed one cycle from rd_en, qualifies each compare.
  - The address is delayed alongside it.
  - A word pair is unequal if any bit differs. X or Z bits count as different (case-inequality semantics).
- On an unequal pair:
  - match is cleared to 0.
  - mismatch_cnt increments.
  - If first_mis_valid==0, capture the delayed address and set first_mis_valid.
- EARLY_ABORT=1: the first mismatch moves the FSM to DONE on the next edge and rd_en drops. The in-flight read returns and is discarded; counters do not change. mismatch_cnt ends at 1.
- abort in RUN or DRAIN:
  - Go to IDLE on the next edge. rd_en and busy drop; in-flight data is ignored.
  - No done pulse is issued.
  - match is forced to 0; first_mis_* keep whatever was captured.
- abort in IDLE or DONE is ignored. start while busy is ignored.
- abort and start in the same IDLE cycle: start wins.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, match=0, mismatch_cnt=0, first_mis_addr=0, first_mis_valid=0, state IDLE.
- Asserting rst_n mid-run forces all outputs to their reset values immediately, without waiting for a clock edge.
- Cycle timeline for start sampled at edge T:
  - busy rises at T+1.
  - rd_en is high from cycle T+1 through cycle T+len, with rd_addr=k in cycle T+1+k.
  - Data for address k is compared in cycle T+2+k.
  - done pulses in cycle T+len+2, and results are stable at that point.
  - busy falls in the same cycle done pulses.
- len==0: done pulses at T+1 with match=1 and mismatch_cnt=0, and rd_en never rises.
- A new start is accepted in the first IDLE cycle after done. The minimum back-to-back period is len+3 cycles.
- All outputs are registered. No combinational path exists from rd_data to any output.

## Test plan
- Identical memories, len=1958 -> rd_en high for 1958 cycles; addresses 0..1957 in order; done at start+1960; match=1; mismatch_cnt=0; first_mis_valid=0.
- Mismatches at addresses 5 and 1000, len=1958, EARLY_ABORT=0 -> match=0, mismatch_cnt=2, first_mis_addr=5.
- Same memories, EARLY_ABORT=1 -> rd_en drops the cycle after the address-5 compare; done pulses in that cycle; mismatch_cnt=1; first_mis_addr=5.
- len=0 -> done one cycle after start, match=1, no rd_en; also len=3000 -> clamped, reads stop at address 1957.
- abort at address 100 -> busy low next cycle, no done pulse, match=0. start pulsed during busy -> ignored, run completes normally.
- rst_n low at address 50 -> all outputs 0 immediately; a fresh start after release completes a full correct compare.
